stream_fifo: RTL and testbench

- Synchronous elastic buffer placed directly upstream of a stream consumer, such as a drain or sink model, or a downstream DSP stage.
- Accepts words on a vld/rdy input stream and stores them in a 2**AW-deep memory.
- Presents the stored words in order on a vld/rdy output stream.
- Absorbs consumer back-pressure, such as a randomly toggling rdy, without losing or duplicating data.

---
 rtl/stream_fifo_ram.sv | 25 ++
 rtl/stream_fifo.sv | 102 ++++++++++
 tb/tb_stream_fifo.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage for stream_fifo: synchronous write, asynchronous read so the
// head word can be loaded into the output register on the same edge it is popped.
module stream_fifo_ram #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo.sv
// Elastic vld/rdy buffer: 2**AW-1 words of memory plus a registered head word, for a total
// capacity of 2**AW words with one cycle of latency through an empty FIFO.
module stream_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [DW-1:0] out_dat,
  input  logic          out_rdy,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);

  localparam int unsigned DN = 2**AW;
  localparam logic [AW:0] CntFull = (AW+1)'(DN);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          r_out_vld;
  logic [DW-1:0] r_out_dat;

  logic [AW:0]   w_mem_cnt;
  logic          w_mem_empty;
  logic          w_wr;
  logic          w_rd;
  logic          w_load;
  logic          w_pop;
  logic          w_bypass;
  logic          w_we;
  logic [DW-1:0] w_rdata;

  // Words held in memory exclude the one sitting in the output register.
  assign w_mem_cnt   = r_cnt - {{AW{1'b0}}, r_out_vld};
  assign w_mem_empty = (w_mem_cnt == '0);

  assign full   = (r_cnt == CntFull);
  assign empty  = (r_cnt == '0);
  assign in_rdy = !full;

  assign w_wr     = in_vld & in_rdy;
  assign w_rd     = r_out_vld & out_rdy;
  assign w_load   = !r_out_vld | w_rd;
  assign w_pop    = w_load & !w_mem_empty;
  assign w_bypass = w_load & w_mem_empty & w_wr;
  assign w_we     = w_wr & !w_bypass;

  stream_fifo_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_waddr(r_wptr),
    .i_wdata(in_dat),
    .i_raddr(r_rptr),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      if (w_we) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr && !w_rd) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_wr && w_rd) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // Memory head has priority; the bypass only fills a register with nothing behind it.
      if (w_pop) begin
        r_out_dat <= w_rdata;
        r_out_vld <= 1'b1;
      end else if (w_bypass) begin
        r_out_dat <= in_dat;
        r_out_vld <= 1'b1;
      end else if (w_load) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign out_vld = r_out_vld;
  assign out_dat = r_out_dat;
  assign cnt     = r_cnt;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo at DW=8, AW=2 (depth 4).
module tb_stream_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clk;
  logic          rst;
  logic          in_vld;
  logic [DW-1:0] in_dat;
  logic          in_rdy;
  logic          out_vld;
  logic [DW-1:0] out_dat;
  logic          out_rdy;
  logic [AW:0]   cnt;
  logic          full;
  logic          empty;

  int n_tests;
  int n_fail;

  stream_fifo #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in_vld (in_vld),
    .in_dat (in_dat),
    .in_rdy (in_rdy),
    .out_vld(out_vld),
    .out_dat(out_dat),
    .out_rdy(out_rdy),
    .cnt    (cnt),
    .full   (full),
    .empty  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] fill_pat [4];
    int pushed;
    int popped;
    int cycles;
    logic       hold;
    logic [7:0] hold_dat;
    logic       wr;
    logic       rd;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_dat  = '0;
    out_rdy = 1'b0;
    step();
    step();
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_dat", 32'(out_dat), 32'd0);
    rst = 1'b0;
    step();

    // 1. Fill and drain
    fill_pat[0] = 8'h11;
    fill_pat[1] = 8'h22;
    fill_pat[2] = 8'h33;
    fill_pat[3] = 8'h44;
    in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_dat = fill_pat[i];
      step();
      check("fill_out_vld", 32'(out_vld), 32'd1);
      check("fill_head", 32'(out_dat), 32'h11);
      check("fill_cnt", 32'(cnt), 32'(i + 1));
    end
    in_vld = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_in_rdy", 32'(in_rdy), 32'd0);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_vld", 32'(out_vld), 32'd1);
      check("drain_dat", 32'(out_dat), 32'(fill_pat[i]));
      step();
    end
    out_rdy = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_out_vld", 32'(out_vld), 32'd0);

    // 2. Latency
    in_vld = 1'b1;
    in_dat = 8'hA5;
    step();
    in_vld = 1'b0;
    check("lat_vld", 32'(out_vld), 32'd1);
    check("lat_dat", 32'(out_dat), 32'hA5);
    check("lat_cnt", 32'(cnt), 32'd1);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    check("lat_empty", 32'(empty), 32'd1);

    // 3. Streaming
    in_vld  = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_dat = 8'(i);
      step();
      check("stream_dat", 32'(out_dat), 32'(i));
      check("stream_cnt", 32'(cnt), 32'd1);
    end
    in_vld = 1'b0;
    step();
    out_rdy = 1'b0;
    check("stream_empty", 32'(empty), 32'd1);

    // 4. Random back-pressure with a counting scoreboard
    pushed = 0;
    popped = 0;
    cycles = 0;
    hold   = 1'b0;
    hold_dat = '0;
    while (popped < 1000 && cycles < 20000) begin
      if (hold) begin
        check("bp_hold_vld", 32'(out_vld), 32'd1);
        check("bp_hold_dat", 32'(out_dat), 32'(hold_dat));
      end
      check("bp_cnt", 32'(cnt), 32'(pushed - popped));
      in_vld  = (pushed < 1000) && ($urandom_range(1) == 1);
      in_dat  = 8'(pushed);
      out_rdy = ($urandom_range(1) == 1);
      wr = in_vld & in_rdy;
      rd = out_vld & out_rdy;
      if (rd) begin
        check("bp_dat", 32'(out_dat), 32'(popped[7:0]));
        popped++;
      end
      hold     = out_vld & !out_rdy;
      hold_dat = out_dat;
      if (wr) pushed++;
      step();
      cycles++;
    end
    check("bp_done", 32'(popped), 32'd1000);
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    check("bp_end_empty", 32'(empty), 32'd1);

    // 5. Full with simultaneous read
    in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_dat = 8'h61 + 8'(i);
      step();
    end
    check("fr_full", 32'(full), 32'd1);
    in_dat  = 8'h99;
    out_rdy = 1'b1;
    check("fr_in_rdy", 32'(in_rdy), 32'd0);
    step();
    in_vld = 1'b0;
    check("fr_cnt", 32'(cnt), 32'd3);
    check("fr_in_rdy_after", 32'(in_rdy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      check("fr_drain", 32'(out_dat), 32'h61 + 32'(i));
      step();
    end
    out_rdy = 1'b0;
    check("fr_empty", 32'(empty), 32'd1);

    // 6. Reset mid-operation
    in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_dat = 8'h71 + 8'(i);
      step();
    end
    in_vld = 1'b0;
    check("mr_cnt_pre", 32'(cnt), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("mr_out_vld", 32'(out_vld), 32'd0);
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_cnt", 32'(cnt), 32'd0);
    #1;
    rst = 1'b0;
    step();
    in_vld = 1'b1;
    in_dat = 8'h5A;
    step();
    in_vld = 1'b0;
    check("mr_push_vld", 32'(out_vld), 32'd1);
    check("mr_push_dat", 32'(out_dat), 32'h5A);
    check("mr_push_cnt", 32'(cnt), 32'd1);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    check("mr_final_empty", 32'(empty), 32'd1);
    check("mr_final_vld", 32'(out_vld), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
